// File: rtl/cnn_defs.sv
// Shared sizes and FSM state type for the CNN job controller.
// Imported by cnn_job_ctrl and cnn_job_obuf.
package cnn_defs;

    localparam int unsigned DATA_WIDTH       = 8;
    localparam int unsigned IFMAP_SIZE       = 8;
    localparam int unsigned KERNEL_SIZE      = 3;
    localparam int unsigned POOL_PIXEL_COUNT = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_IF,
        ACC_RST,
        RUN,
        DRAIN
    } job_state_t;

endpackage

// File: rtl/cnn_job_obuf.sv
// Capture register for the pooled ofmap plus read index and last flag.
// Ports: clk, reset (async, active-low); i_capture loads i_ofmap and
//  rewinds the index; i_pop advances it; o_data is the word at the
//  index; o_last is high on the final word.
module cnn_job_obuf
    import cnn_defs::*;
(
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         i_capture,
    input  logic                                         i_pop,
    input  logic [POOL_PIXEL_COUNT-1:0][DATA_WIDTH-1:0]  i_ofmap,
    output logic [DATA_WIDTH-1:0]                        o_data,
    output logic                                         o_last
);

    localparam int unsigned NP = POOL_PIXEL_COUNT;
    localparam int unsigned IW = $clog2(NP + 1);

    logic [NP-1:0][DATA_WIDTH-1:0] r_buf;
    logic [IW-1:0]                 r_idx;
    logic                          w_last;

    assign w_last = (r_idx == IW'(NP - 1));
    assign o_last = w_last;
    assign o_data = r_buf[r_idx];

    // Index parks on the final word so the output holds after the burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf <= '0;
            r_idx <= '0;
        end else if (i_capture) begin
            r_buf <= i_ofmap;
            r_idx <= '0;
        end else if (i_pop && !w_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_job_ctrl.sv
// Job sequencer: loads kernel and ifmap from a valid/ready stream, runs the
// accelerator with a timeout, then streams the pooled ofmap out with last.
// Ports: clk, reset (async, active-low), start, busy, error;
//  load stream in_valid/in_ready/in_data; result stream out_valid/
//  out_ready/out_data/out_last; accelerator side acc_reset, acc_en,
//  acc_ifmap, acc_weights, acc_ofmap, acc_done.
module cnn_job_ctrl
    import cnn_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   error,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   acc_reset,
    output logic                   acc_en,
    output logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][DATA_WIDTH-1:0]
                                   acc_ifmap,
    output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]
                                   acc_weights,
    input  logic [POOL_PIXEL_COUNT-1:0][DATA_WIDTH-1:0]
                                   acc_ofmap,
    input  logic                   acc_done
);

    localparam int unsigned NW  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned NI  = IFMAP_SIZE * IFMAP_SIZE;
    localparam int unsigned CW  = $clog2(NI + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WAW = $clog2(NW);
    localparam int unsigned IAW = $clog2(NI);

    job_state_t r_state;
    job_state_t w_next;

    logic [CW-1:0]                 r_cnt;
    logic [TW-1:0]                 r_tmo;
    logic                          r_error;
    logic [NW-1:0][DATA_WIDTH-1:0] r_wbuf;
    logic [NI-1:0][DATA_WIDTH-1:0] r_ibuf;

    logic w_start_ok;
    logic w_capture;
    logic w_timeout;
    logic w_in_beat;
    logic w_obuf_last;

    // Flat row-major buffers map directly onto the packed 2-D ports.
    assign acc_weights = r_wbuf;
    assign acc_ifmap   = r_ibuf;
    assign error       = r_error;
    assign w_in_beat   = in_valid && in_ready;
    assign out_last    = out_valid && w_obuf_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        acc_reset  = 1'b0;
        acc_en     = 1'b0;
        w_start_ok = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start_ok = 1'b1;
                    w_next     = LOAD_W;
                end
            end
            LOAD_W: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == CW'(NW - 1)) begin
                    w_next = LOAD_IF;
                end
            end
            LOAD_IF: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == CW'(NI - 1)) begin
                    w_next = ACC_RST;
                end
            end
            ACC_RST: begin
                acc_reset = 1'b1;
                w_next    = RUN;
            end
            RUN: begin
                acc_en = 1'b1;
                // Done takes priority over a coincident timeout.
                if (acc_done) begin
                    w_capture = 1'b1;
                    w_next    = DRAIN;
                end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && w_obuf_last) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_error <= 1'b0;
            r_wbuf  <= '0;
            r_ibuf  <= '0;
        end else begin
            if (w_start_ok) begin
                r_error <= 1'b0;
                r_cnt   <= '0;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            if (w_in_beat) begin
                if (r_state == LOAD_W) begin
                    r_wbuf[r_cnt[WAW-1:0]] <= in_data;
                    if (r_cnt == CW'(NW - 1)) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_ibuf[r_cnt[IAW-1:0]] <= in_data;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (acc_reset) begin
                r_tmo <= '0;
            end else if (acc_en) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    cnn_job_obuf u_obuf (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_capture),
        .i_pop     (out_valid && out_ready),
        .i_ofmap   (acc_ofmap),
        .o_data    (out_data),
        .o_last    (w_obuf_last)
    );

endmodule
